if_stage: RTL

Instruction-fetch stage of the LA32R pipeline. It owns the fetch PC, issues one word read at a time on the instruction SRAM-like bus, and hands each fetched instruction with its PC to ID through the valid/allowin handshake. It consumes the branch redirect (taken flag plus computed target) produced by the EX-stage branch-target logic, cancelling any wrong-path fetch.

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the LA32R instruction-fetch stage: reset PC, the
// fetch-to-decode bus layout and the fetch FSM encoding.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
    localparam int          FS_TO_DS_BUS_WD = 65;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fs_state_t;

    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// SRAM-like instruction bus: one word read, request/address handshake
// followed by a separate data-return handshake.
interface if_stage_if;
    import if_stage_pkg::*;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one read in flight
// and hands {adef, pc, inst} to ID, dropping anything fetched down a wrong path.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    if_stage_if.master                 inst_sram
);

    fs_state_t   state,    state_n;
    logic [31:0] req_pc,   req_pc_n;
    logic [31:0] fs_pc,    fs_pc_n;
    logic [31:0] inst_buf, inst_buf_n;
    logic        adef_buf, adef_buf_n;
    logic        cancel,   cancel_n;

    logic        req_aligned;
    logic        req_fire;
    logic        data_fire;
    fs_to_ds_t   bus_q;

    assign req_aligned = !pc_misaligned(req_pc);
    assign req_fire    = inst_sram.inst_sram_req && inst_sram.inst_sram_addr_ok;
    assign data_fire   = (state == S_WAIT) && inst_sram.inst_sram_data_ok;

    assign inst_sram.inst_sram_req  = (state == S_REQ) && !reset && req_aligned;
    assign inst_sram.inst_sram_addr = reset ? RESET_PC : req_pc;

    assign bus_q.adef = adef_buf;
    assign bus_q.pc   = fs_pc;
    assign bus_q.inst = inst_buf;

    // A redirect in the same cycle kills whatever is being offered to ID.
    assign fs_to_ds_valid = (state == S_HOLD) && !br_taken && !reset;
    assign fs_to_ds_bus   = reset ? '0 : bus_q;

    always_comb begin
        state_n    = state;
        req_pc_n   = req_pc;
        fs_pc_n    = fs_pc;
        inst_buf_n = inst_buf;
        adef_buf_n = adef_buf;
        cancel_n   = cancel;

        case (state)
            S_REQ: begin
                if (br_taken) begin
                    req_pc_n = br_target;
                    // The request accepted this cycle is wrong-path; its data must be eaten.
                    if (req_fire) begin
                        cancel_n = 1'b1;
                        state_n  = S_WAIT;
                    end
                end else if (!req_aligned) begin
                    fs_pc_n    = req_pc;
                    adef_buf_n = 1'b1;
                    inst_buf_n = '0;
                    state_n    = S_HOLD;
                end else if (req_fire) begin
                    fs_pc_n  = req_pc;
                    req_pc_n = seq_pc(req_pc);
                    state_n  = S_WAIT;
                end
            end

            S_WAIT: begin
                if (br_taken) begin
                    req_pc_n = br_target;
                    if (data_fire) begin
                        cancel_n = 1'b0;
                        state_n  = S_REQ;
                    end else begin
                        cancel_n = 1'b1;
                    end
                end else if (data_fire) begin
                    if (cancel) begin
                        cancel_n = 1'b0;
                        state_n  = S_REQ;
                    end else begin
                        inst_buf_n = inst_sram.inst_sram_rdata;
                        adef_buf_n = 1'b0;
                        state_n    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (br_taken) begin
                    req_pc_n = br_target;
                    state_n  = S_REQ;
                end else if (ds_allowin) begin
                    state_n = S_REQ;
                end
            end

            default: begin
                state_n = S_REQ;
            end
        endcase
    end

    // An in-flight bus request is reset along with the bus, so cancel clears too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            req_pc   <= RESET_PC;
            fs_pc    <= '0;
            inst_buf <= '0;
            adef_buf <= 1'b0;
            cancel   <= 1'b0;
        end else begin
            state    <= state_n;
            req_pc   <= req_pc_n;
            fs_pc    <= fs_pc_n;
            inst_buf <= inst_buf_n;
            adef_buf <= adef_buf_n;
            cancel   <= cancel_n;
        end
    end

endmodule
